// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the FPGA configuration loader.
// State encoding and counter sizing used by the core.
package fpga_cfg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CLB  = 3'd1;
  localparam state_t ST_CONN = 3'd2;
  localparam state_t ST_DONE = 3'd3;
  localparam state_t ST_ERR  = 3'd4;

  // Bit counter must hold 0 .. clb_len+conn_len inclusive.
  function automatic int cnt_w(
    input int clb_len,
    input int conn_len
  );
    return $clog2(clb_len + conn_len + 1);
  endfunction

endpackage

// File: rtl/fpga_cfg_serializer.sv
// Word-to-bit serializer: holds one config word and shifts it out
// LSB first, one bit per cycle, with a valid/ready word handshake.
module cfg_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              ready_o,
  output logic              bit_vld_o,
  output logic              bit_o
);

  localparam int NW = $clog2(WORD_W + 1);

  logic [NW-1:0]     cnt_q;
  logic [NW-1:0]     cnt_d;
  logic [WORD_W-1:0] sr_q;
  logic [WORD_W-1:0] sr_d;
  logic              take;

  assign bit_vld_o = (cnt_q != '0);
  assign bit_o     = sr_q[0];

  // Refill when empty or when the final bit leaves this cycle,
  // so consecutive words stream without a bubble.
  assign ready_o = en_i && !hold_i && (cnt_q <= NW'(1));
  assign take    = valid_i && ready_o;

  // Next word / shift / flush selection.
  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (flush_i) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (take) begin
      cnt_d = NW'(WORD_W);
      sr_d  = data_i;
    end else if (bit_vld_o) begin
      cnt_d = cnt_q - NW'(1);
      sr_d  = sr_q >> 1;
    end
  end

  // Word register and remaining-bit count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/fpga_cfg_core.sv
// FPGA configuration core: loads the CLB and connection scan chains
// from a word stream, then enables the fabric and its I/O.
module fpga_cfg_core
  import fpga_cfg_pkg::*;
#(
  parameter int IO_W       = 10,
  parameter int WORD_W     = 8,
  parameter int CLB_LEN    = 512,
  parameter int CONN_LEN   = 4096,
  parameter int IO_REVERSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_abort,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic              clb_scan_en,
  output logic              clb_scan_in,
  output logic              conn_scan_en,
  output logic              conn_scan_in,
  output logic              fab_run,
  input  logic [IO_W-1:0]   pad_in,
  output logic [IO_W-1:0]   fab_in,
  input  logic [IO_W-1:0]   fab_out,
  output logic [IO_W-1:0]   pad_out
);

  localparam int CW = cnt_w(CLB_LEN, CONN_LEN);

  localparam logic [CW-1:0] CLB_LAST = CW'(CLB_LEN - 1);
  localparam logic [CW-1:0] ALL_LAST = CW'(CLB_LEN + CONN_LEN - 1);

  state_t          st_q;
  state_t          st_d;
  logic [CW-1:0]   bcnt_q;
  logic [CW-1:0]   bcnt_d;
  logic [IO_W-1:0] pad_q;
  logic [IO_W-1:0] pad_map;

  logic loading;
  logic bit_vld;
  logic bit_val;
  logic last_bit;
  logic flush;
  logic hold;

  assign loading  = (st_q == ST_CLB) || (st_q == ST_CONN);
  assign last_bit = (st_q == ST_CONN) && bit_vld
                    && (bcnt_q == ALL_LAST);

  // No new word on the final bit or when the load is about to end.
  assign hold = last_bit || cfg_start || cfg_abort;

  cfg_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .en_i      (loading),
    .hold_i    (hold),
    .flush_i   (flush),
    .valid_i   (cfg_valid),
    .data_i    (cfg_data),
    .ready_o   (cfg_ready),
    .bit_vld_o (bit_vld),
    .bit_o     (bit_val)
  );

  // Load sequencing: chain routing, bit counting, abort/restart.
  always_comb begin
    st_d   = st_q;
    bcnt_d = bcnt_q;
    flush  = 1'b0;
    unique case (st_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (cfg_start) begin
          st_d   = ST_CLB;
          bcnt_d = '0;
          flush  = 1'b1;
        end
      end
      ST_CLB, ST_CONN: begin
        if (cfg_start || cfg_abort) begin
          st_d  = ST_ERR;
          flush = 1'b1;
        end else if (bit_vld) begin
          bcnt_d = bcnt_q + CW'(1);
          if (st_q == ST_CLB && bcnt_q == CLB_LAST) begin
            st_d = ST_CONN;
          end
          if (last_bit) begin
            st_d  = ST_DONE;
            flush = 1'b1;
          end
        end
      end
      default: begin
        st_d  = ST_IDLE;
        flush = 1'b1;
      end
    endcase
  end

  // State and bit counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      bcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign cfg_busy = loading;
  assign cfg_done = (st_q == ST_DONE);
  assign cfg_err  = (st_q == ST_ERR);
  assign fab_run  = cfg_done;

  assign clb_scan_en  = (st_q == ST_CLB) && bit_vld;
  assign clb_scan_in  = clb_scan_en && bit_val;
  assign conn_scan_en = (st_q == ST_CONN) && bit_vld;
  assign conn_scan_in = conn_scan_en && bit_val;

  // Pad/fabric bit mapping in both directions.
  always_comb begin
    fab_in  = '0;
    pad_map = '0;
    for (int i = 0; i < IO_W; i++) begin
      if (IO_REVERSE != 0) begin
        fab_in[i]  = pad_in[IO_W-1-i];
        pad_map[i] = fab_out[IO_W-1-i];
      end else begin
        fab_in[i]  = pad_in[i];
        pad_map[i] = fab_out[i];
      end
    end
  end

  // Registered pad outputs, held at zero until the fabric runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_q <= '0;
    end else begin
      pad_q <= fab_run ? pad_map : '0;
    end
  end

  assign pad_out = fab_run ? pad_q : '0;

endmodule

// File: tb/tb_fpga_cfg_core.sv
// Self-checking bench for fpga_cfg_core.
// Scoreboard of expected scan bits plus vector tables.
`timescale 1ns/1ps
module tb_fpga_cfg_core;

  localparam int IO_W  = 10;
  localparam int WW    = 8;
  localparam int CLB   = 12;
  localparam int CONN  = 20;
  localparam int CLB_B = 10;

  typedef struct packed {
    logic conn;
    logic b;
  } sb_t;

  typedef struct {
    logic [IO_W-1:0] vin;
    logic [IO_W-1:0] vexp;
  } io_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic a_start = 0, a_valid = 0, a_abort = 0;
  logic [WW-1:0]   a_data = '0;
  logic [IO_W-1:0] a_pad_in = '0, a_fab_out = '0;
  logic a_ready, a_busy, a_done, a_err, a_run;
  logic a_clb_en, a_clb_in, a_conn_en, a_conn_in;
  logic [IO_W-1:0] a_fab_in, a_pad_out;
  logic [8:0] a_flags;

  logic b_start = 0, b_valid = 0, b_abort = 0;
  logic [WW-1:0]   b_data = '0;
  logic [IO_W-1:0] b_pad_in = '0, b_fab_out = '0;
  logic b_ready, b_busy, b_done, b_err, b_run;
  logic b_clb_en, b_clb_in, b_conn_en, b_conn_in;
  logic [IO_W-1:0] b_fab_in, b_pad_out;

  fpga_cfg_core #(
    .IO_W(IO_W), .WORD_W(WW), .CLB_LEN(CLB),
    .CONN_LEN(CONN), .IO_REVERSE(1)
  ) u_a (
    .clk(clk), .rst(rst),
    .cfg_start(a_start), .cfg_valid(a_valid),
    .cfg_ready(a_ready), .cfg_data(a_data),
    .cfg_abort(a_abort), .cfg_busy(a_busy),
    .cfg_done(a_done), .cfg_err(a_err),
    .clb_scan_en(a_clb_en), .clb_scan_in(a_clb_in),
    .conn_scan_en(a_conn_en), .conn_scan_in(a_conn_in),
    .fab_run(a_run), .pad_in(a_pad_in),
    .fab_in(a_fab_in), .fab_out(a_fab_out),
    .pad_out(a_pad_out)
  );

  fpga_cfg_core #(
    .IO_W(IO_W), .WORD_W(WW), .CLB_LEN(CLB_B),
    .CONN_LEN(CONN), .IO_REVERSE(1)
  ) u_b (
    .clk(clk), .rst(rst),
    .cfg_start(b_start), .cfg_valid(b_valid),
    .cfg_ready(b_ready), .cfg_data(b_data),
    .cfg_abort(b_abort), .cfg_busy(b_busy),
    .cfg_done(b_done), .cfg_err(b_err),
    .clb_scan_en(b_clb_en), .clb_scan_in(b_clb_in),
    .conn_scan_en(b_conn_en), .conn_scan_in(b_conn_in),
    .fab_run(b_run), .pad_in(b_pad_in),
    .fab_in(b_fab_in), .fab_out(b_fab_out),
    .pad_out(b_pad_out)
  );

  assign a_flags = {a_ready, a_busy, a_done, a_err, a_run,
                    a_clb_en, a_clb_in, a_conn_en, a_conn_in};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mb = 0;
  int nclb = 0;
  int nconn = 0;
  int npulse = 0;
  int last_cyc = 0;
  int nb = 0;
  sb_t sbq[$];
  sb_t blog[16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for instance a.
  always @(negedge clk) begin
    sb_t e;
    if (a_clb_en || a_conn_en) begin
      npulse++;
      last_cyc = cyc;
      if (a_clb_en) nclb++;
      else nconn++;
      chk("both_en", {31'd0, a_clb_en && a_conn_en}, 0);
      if (sbq.size() == 0) begin
        chk("unexpected_bit", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("scan_bit",
            {30'd0, a_conn_en, a_conn_en ? a_conn_in : a_clb_in},
            {30'd0, e.conn, e.b});
      end
    end
  end

  // Bit log for instance b.
  always @(negedge clk) begin
    if ((b_clb_en || b_conn_en) && nb < 16) begin
      blog[nb] = {b_conn_en, b_conn_en ? b_conn_in : b_clb_in};
      nb++;
    end
  end

  task automatic push_word(input logic [WW-1:0] w);
    for (int i = 0; i < WW; i++) begin
      if (mb < CLB) sbq.push_back({1'b0, w[i]});
      else if (mb < CLB + CONN) sbq.push_back({1'b1, w[i]});
      mb++;
    end
  endtask

  task automatic send_a(input logic [WW-1:0] w);
    int k = 0;
    a_valid = 1'b1;
    a_data  = w;
    @(negedge clk);
    while (!a_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (!a_ready) chk("send_a_timeout", 0, 1);
    else push_word(w);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [WW-1:0] w);
    int k = 0;
    b_valid = 1'b1;
    b_data  = w;
    @(negedge clk);
    while (!b_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (!b_ready) chk("send_b_timeout", 0, 1);
    @(posedge clk);
    #1;
    b_valid = 1'b0;
  endtask

  task automatic start_a();
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    a_start = 0; a_valid = 0; a_abort = 0;
    b_start = 0; b_valid = 0; b_abort = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    mb = 0; nclb = 0; nconn = 0; npulse = 0; nb = 0;
  endtask

  task automatic wait_done(output int dc);
    int k = 0;
    dc = -1;
    while (k < 60) begin
      @(posedge clk);
      #2;
      if (a_done) begin
        dc = cyc;
        break;
      end
      k++;
    end
    chk("done_seen", {31'd0, a_done}, 1);
  endtask

  task automatic wait_pulses(input int n);
    int k = 0;
    while (npulse != n && k < 60) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("pulse_reach", npulse, n);
  endtask

  io_vec_t fin_tv[4];
  io_vec_t pad_tv[3];
  sb_t     b_tv[11];

  initial begin
    int dc;
    int p0;
    logic [IO_W-1:0] prev;

    fin_tv[0] = '{10'b0000000001, 10'b1000000000};
    fin_tv[1] = '{10'b1100000000, 10'b0000000011};
    fin_tv[2] = '{10'b1010101010, 10'b0101010101};
    fin_tv[3] = '{10'b0000011111, 10'b1111100000};
    pad_tv[0] = '{10'b0000000001, 10'b1000000000};
    pad_tv[1] = '{10'b0000000110, 10'b0110000000};
    pad_tv[2] = '{10'b1111100000, 10'b0000011111};
    b_tv[0]  = 2'b01; b_tv[1] = 2'b00; b_tv[2]  = 2'b01;
    b_tv[3]  = 2'b00; b_tv[4] = 2'b00; b_tv[5]  = 2'b01;
    b_tv[6]  = 2'b00; b_tv[7] = 2'b01; b_tv[8]  = 2'b00;
    b_tv[9]  = 2'b00; b_tv[10] = 2'b11;

    // Reset state.
    a_fab_out = 10'h3FF;
    reset_all();
    @(negedge clk);
    chk("reset_flags", a_flags, 0);
    chk("reset_pad_out", a_pad_out, 0);

    // Combinational input mapping.
    foreach (fin_tv[i]) begin
      a_pad_in = fin_tv[i].vin;
      #1;
      chk("fab_in_map", a_fab_in, fin_tv[i].vexp);
    end

    // Abort ignored in IDLE; start+abort in IDLE loads.
    @(posedge clk); #1;
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    @(negedge clk);
    chk("idle_abort", a_flags, 0);
    @(posedge clk); #1;
    a_start = 1'b1; a_abort = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; a_abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", {a_busy, a_err}, 2'b10);
    @(posedge clk); #1;
    start_a();
    @(negedge clk);
    chk("restart_in_load_err", {a_busy, a_err}, 2'b01);

    // Full load, 4 back-to-back words.
    reset_all();
    start_a();
    a_fab_out = 10'h3FF;
    send_a(8'h5A);
    send_a(8'hC3);
    send_a(8'h0F);
    send_a(8'h96);
    chk("pad_out_predone", a_pad_out, 0);
    wait_done(dc);
    chk("done_latency", dc, last_cyc + 1);
    chk("clb_pulses", nclb, CLB);
    chk("conn_pulses", nconn, CONN);
    chk("sb_empty1", sbq.size(), 0);
    chk("done_flags", a_flags, 9'b001010000);
    a_valid = 1'b1;
    a_data = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      chk("done_ready", {31'd0, a_ready}, 0);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk); #2;
    prev = 10'h3FF;
    foreach (pad_tv[i]) begin
      a_fab_out = pad_tv[i].vin;
      #1;
      chk("pad_out_hold", a_pad_out, prev);
      @(posedge clk); #2;
      chk("pad_out_map", a_pad_out, pad_tv[i].vexp);
      prev = pad_tv[i].vexp;
    end

    // Stall between words 2 and 3.
    reset_all();
    start_a();
    send_a(8'hB1);
    send_a(8'h6E);
    repeat (8) @(posedge clk);
    #2;
    p0 = npulse;
    chk("pre_gap_bits", p0, 16);
    repeat (5) @(posedge clk);
    #2;
    chk("gap_no_bits", npulse, p0);
    chk("gap_ready", {a_ready, a_busy}, 2'b11);
    send_a(8'h27);
    send_a(8'hD4);
    wait_done(dc);
    chk("gap_clb", nclb, CLB);
    chk("gap_conn", nconn, CONN);
    chk("sb_empty2", sbq.size(), 0);

    // Abort at bit 15.
    reset_all();
    start_a();
    a_fab_out = 10'h001;
    send_a(8'h33);
    send_a(8'hCC);
    wait_pulses(15);
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    @(negedge clk);
    chk("abort_flags", a_flags, 9'b000100000);
    chk("abort_pad_out", a_pad_out, 0);
    chk("abort_sb", sbq.size(), 0);
    @(posedge clk); #1;
    start_a();
    @(negedge clk);
    chk("err_cleared", {a_busy, a_err}, 2'b10);

    // Reset at bit 7.
    reset_all();
    start_a();
    a_fab_out = 10'h3FF;
    send_a(8'hE7);
    wait_pulses(7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("midrst_flags", a_flags, 0);
    chk("midrst_pad_out", a_pad_out, 0);

    // CLB_LEN=10 split across words 0xA5, 0x3C.
    reset_all();
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    send_b(8'hA5);
    send_b(8'h3C);
    repeat (16) @(posedge clk);
    #2;
    chk("b_bits", nb, 16);
    foreach (b_tv[i]) begin
      chk($sformatf("b_bit%0d", i), blog[i], b_tv[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
